// File: rtl/shake_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shake_arbiter
// Purpose  : Two-requester arbiter in front of a single SHAKE core. A granted
//            requester owns the core's absorb (din) and squeeze (dout) streams,
//            which are routed combinationally. A transaction ends on the
//            owner's force_done, on the owner dropping its request, or on the
//            idle-handshake watchdog. Every end pulses shake_force_done and is
//            followed by one FLUSH cycle with no grant.
// Ports    : clk, rst (async, active-low)
//            req0/req1, gnt0/gnt1           - request / registered grant
//            dinX_valid/dinX/dinX_ready     - requester absorb streams
//            doutX_ready/doutX_valid/doutX  - requester squeeze streams
//            force_done0/force_done1        - requester end-of-transaction
//            shake_din_*/shake_dout_*       - core-side streams
//            shake_force_done               - core reset/finish pulse
//            timeout_err                    - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module shake_arbiter #(
  parameter int          WIDTH   = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             din0_valid,
  input  logic [WIDTH-1:0] din0,
  output logic             din0_ready,
  input  logic             din1_valid,
  input  logic [WIDTH-1:0] din1,
  output logic             din1_ready,
  input  logic             dout0_ready,
  output logic             dout0_valid,
  output logic [WIDTH-1:0] dout0,
  input  logic             dout1_ready,
  output logic             dout1_valid,
  output logic [WIDTH-1:0] dout1,
  input  logic             force_done0,
  input  logic             force_done1,
  output logic             shake_din_valid,
  input  logic             shake_din_ready,
  output logic [WIDTH-1:0] shake_din,
  input  logic             shake_dout_valid,
  output logic             shake_dout_ready,
  input  logic [WIDTH-1:0] shake_dout,
  output logic             shake_force_done,
  output logic             timeout_err
);

  // A disabled watchdog still keeps a 1-bit counter so widths stay legal.
  localparam int c_cnt_w = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_lim = (TIMEOUT == 0) ? '0 : c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
  localparam logic c_wdog_en = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY0 = 2'd1,
    S_BUSY1 = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last;      // port of the most recent grant
  logic                 w_last_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_err;
  logic                 w_err_set;
  logic                 w_sel;       // granted port when busy
  logic                 w_req_sel;
  logic                 w_fd_sel;
  logic                 w_req_oth;
  logic                 w_hs;
  logic                 w_expire;

  assign gnt0        = (r_state == S_BUSY0);
  assign gnt1        = (r_state == S_BUSY1);
  assign timeout_err = r_err;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_cnt_nxt        = '0;
    w_err_set        = 1'b0;
    w_hs             = 1'b0;
    w_expire         = 1'b0;
    w_sel            = (r_state == S_BUSY1);
    w_req_sel        = w_sel ? req1 : req0;
    w_fd_sel         = w_sel ? force_done1 : force_done0;
    // In FLUSH r_last names the port that just finished; the other port wins.
    w_req_oth        = r_last ? req0 : req1;
    shake_din_valid  = 1'b0;
    shake_din        = '0;
    shake_dout_ready = 1'b0;
    shake_force_done = 1'b0;
    din0_ready       = 1'b0;
    din1_ready       = 1'b0;
    dout0_valid      = 1'b0;
    dout1_valid      = 1'b0;
    dout0            = '0;
    dout1            = '0;

    case (r_state)
      S_IDLE: begin
        if (req0 && req1) begin
          w_state_nxt = r_last ? S_BUSY0 : S_BUSY1;
          w_last_nxt  = ~r_last;
        end else if (req0) begin
          w_state_nxt = S_BUSY0;
          w_last_nxt  = 1'b0;
        end else if (req1) begin
          w_state_nxt = S_BUSY1;
          w_last_nxt  = 1'b1;
        end
      end

      S_BUSY0, S_BUSY1: begin
        shake_din_valid  = w_sel ? din1_valid  : din0_valid;
        shake_din        = w_sel ? din1        : din0;
        shake_dout_ready = w_sel ? dout1_ready : dout0_ready;
        if (w_sel) begin
          din1_ready  = shake_din_ready;
          dout1_valid = shake_dout_valid;
          dout1       = shake_dout;
        end else begin
          din0_ready  = shake_din_ready;
          dout0_valid = shake_dout_valid;
          dout0       = shake_dout;
        end
        w_hs     = (shake_din_valid && shake_din_ready) ||
                   (shake_dout_valid && shake_dout_ready);
        // Fires on the TIMEOUT-th consecutive cycle without a handshake.
        w_expire = c_wdog_en && !w_hs && (r_cnt == c_cnt_lim);
        if (w_fd_sel || !w_req_sel || w_expire) begin
          // All end causes share one pulse; expiry also flags the error.
          shake_force_done = 1'b1;
          w_err_set        = w_expire;
          w_state_nxt      = S_FLUSH;
        end else if (!w_hs) begin
          w_cnt_nxt = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
        end
      end

      S_FLUSH: begin
        if (w_req_oth) begin
          w_state_nxt = r_last ? S_BUSY0 : S_BUSY1;
          w_last_nxt  = ~r_last;
        end else if (r_last ? req1 : req0) begin
          w_state_nxt = r_last ? S_BUSY1 : S_BUSY0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shake_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shake_arbiter
// Purpose  : Scoreboard bench for shake_arbiter. A stimulus process drives
//            inputs each cycle and pushes the reference model's expected
//            outputs into a queue; a monitor pops and compares on the falling
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shake_arbiter;

  localparam int W  = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic req0, req1, fd0, fd1, v0, v1, o0r, o1r, sir, sov;
  logic [W-1:0] d0, d1, sdo;
  logic g0, g1, i0r, i1r, o0v, o1v, sdv, sdr, sfd, terr;
  logic [W-1:0] o0, o1, sd;

  shake_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .gnt0(g0), .gnt1(g1),
    .din0_valid(v0), .din0(d0), .din0_ready(i0r),
    .din1_valid(v1), .din1(d1), .din1_ready(i1r),
    .dout0_ready(o0r), .dout0_valid(o0v), .dout0(o0),
    .dout1_ready(o1r), .dout1_valid(o1v), .dout1(o1),
    .force_done0(fd0), .force_done1(fd1),
    .shake_din_valid(sdv), .shake_din_ready(sir), .shake_din(sd),
    .shake_dout_valid(sov), .shake_dout_ready(sdr), .shake_dout(sdo),
    .shake_force_done(sfd), .timeout_err(terr)
  );

  typedef struct packed {
    logic g0, g1, sdv, sdr, sfd, err, i0r, i1r, o0v, o1v;
    logic [W-1:0] sd, o0, o1;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the core (0/1), 2 = nobody, 3 = flushing.
  int m_owner, m_last, m_run;
  bit m_err;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 2; m_last = 1; m_run = 0; m_err = 1'b0;
  endtask

  task automatic grant(input int q);
    m_owner = q; m_last = q; m_run = 0;
  endtask

  // Expected outputs for the inputs currently driven, then the state the
  // arbiter should hold after the coming rising edge.
  task automatic model_push();
    exp_t e;
    bit rq[2], fd[2], busy, hs, expire, fin;
    int p;
    rq[0] = req0; rq[1] = req1; fd[0] = fd0; fd[1] = fd1;
    e = '0;
    p = m_owner;
    busy = (p == 0) || (p == 1);
    if (busy) begin
      e.g0  = (p == 0);
      e.g1  = (p == 1);
      e.sdv = (p == 0) ? v0 : v1;
      e.sd  = (p == 0) ? d0 : d1;
      e.sdr = (p == 0) ? o0r : o1r;
      if (p == 0) begin e.i0r = sir; e.o0v = sov; e.o0 = sdo; end
      else        begin e.i1r = sir; e.o1v = sov; e.o1 = sdo; end
    end
    hs     = busy && ((e.sdv && sir) || (sov && e.sdr));
    expire = busy && !hs && (m_run + 1 >= TO);
    fin    = busy && (fd[p] || !rq[p] || expire);
    e.sfd  = fin;
    e.err  = m_err;
    exp_q.push_back(e);
    if (busy) begin
      if (fin) begin
        if (expire) m_err = 1'b1;
        m_owner = 3;
      end else begin
        m_run = hs ? 0 : m_run + 1;
      end
    end else if (m_owner == 2) begin
      if (rq[0] && rq[1]) grant(1 - m_last);
      else if (rq[0])     grant(0);
      else if (rq[1])     grant(1);
    end else begin
      if (rq[1 - m_last])  grant(1 - m_last);
      else if (rq[m_last]) grant(m_last);
      else                 m_owner = 2;
    end
  endtask

  task automatic step();
    model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; fd0 = 0; fd1 = 0; v0 = 0; v1 = 0;
    o0r = 0; o1r = 0; sir = 0; sov = 0;
    d0 = $urandom; d1 = $urandom; sdo = $urandom;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt0", g0, e.g0);
      chk("gnt1", g1, e.g1);
      chk("shake_din_valid", sdv, e.sdv);
      chk("shake_din", sd, e.sd);
      chk("shake_dout_ready", sdr, e.sdr);
      chk("shake_force_done", sfd, e.sfd);
      chk("timeout_err", terr, e.err);
      chk("din0_ready", i0r, e.i0r);
      chk("din1_ready", i1r, e.i1r);
      chk("dout0_valid", o0v, e.o0v);
      chk("dout1_valid", o1v, e.o1v);
      chk("dout0", o0, e.o0);
      chk("dout1", o1, e.o1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    model_reset();
    // Active inputs during reset must not leak through.
    req0 = 1; v0 = 1; sir = 1; sov = 1; o0r = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", g0, 0);
    chk("rst_gnt1", g1, 0);
    chk("rst_shake_din_valid", sdv, 0);
    chk("rst_shake_dout_ready", sdr, 0);
    chk("rst_din0_ready", i0r, 0);
    chk("rst_dout0_valid", o0v, 0);
    chk("rst_force_done", sfd, 0);
    chk("rst_timeout_err", terr, 0);
    idle_inputs();
    rst = 1;

    // Tie after reset -> port 0; force_done0 ends; FLUSH; then port 1.
    req0 = 1; req1 = 1; step();
    fd0 = 1; step();
    fd0 = 0; step();
    step(); step();
    req1 = 0; step();
    req0 = 0; step(); step();

    // Port 1 absorbs a word; port 0 sees no ready.
    req1 = 1; step();
    v1 = 1; sir = 1; d1 = 32'h40000740; v0 = 1; step(); step();
    req1 = 0; v1 = 0; v0 = 0; sir = 0; step(); step();

    // force_done1 while port 0 owns the core is ignored.
    req0 = 1; step();
    fd1 = 1; step(); step();
    fd1 = 0; req0 = 0; step(); step();

    // Port 1 drops its request mid-squeeze.
    req1 = 1; step();
    sov = 1; o1r = 1; sdo = $urandom; step(); step();
    req1 = 0; step(); step(); step();
    sov = 0; o1r = 0;

    // Watchdog: grant held with no handshakes.
    req0 = 1; repeat (TO + 4) step();
    req0 = 0; step(); step();
    req1 = 1; step();
    v1 = 1; sir = 1; step();
    req1 = 0; v1 = 0; sir = 0; step(); step();
    chk("timeout_err_sticky", terr, 1);

    // Asynchronous reset during BUSY0.
    req0 = 1; step(); step();
    v0 = 1; sir = 1;
    #1 rst = 0;
    #1;
    chk("async_gnt0", g0, 0);
    chk("async_shake_din_valid", sdv, 0);
    chk("async_force_done", sfd, 0);
    model_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1;
    req0 = 1; req1 = 1; step(); step();
    req0 = 0; req1 = 0; step(); step();

    // Randomized traffic with periodic quiet stretches to reach the watchdog.
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom_range(0, 7) != 0);
      req1 = ($urandom_range(0, 7) != 0);
      fd0  = ($urandom_range(0, 31) == 0);
      fd1  = ($urandom_range(0, 31) == 0);
      v0 = $urandom; v1 = $urandom; o0r = $urandom; o1r = $urandom;
      sir = $urandom; sov = $urandom;
      d0 = $urandom; d1 = $urandom; sdo = $urandom;
      if ((i % 150) >= 100 && (i % 150) < 130) begin
        v0 = 0; v1 = 0; sir = 0; sov = 0; fd0 = 0; fd1 = 0;
      end
      step();
    end

    idle_inputs();
    step(); step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
